pc_sequencer: RTL

//  Registered program-counter sequencer for the RV32/RV64 core fetch stage.
//  - Owns the architectural PC and resolves every RV branch funct3.
//  - Handles JAL/JALR redirects and traps misaligned targets.
//  - Runs a FENCE drain handshake with timeout, recording the predecessor/successor PCs.
//  - Sits between decode/ALU (conditions, targets) and instruction fetch (pc, flush).

---
 rtl/pc_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Registered program-counter sequencer for the fetch stage: resolves branches and
// jumps, traps misaligned redirect targets and sequences FENCE drains with a timeout.
module pc_sequencer #(
    parameter int              XLEN          = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR  = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR   = {{(XLEN-9){1'b0}}, 9'h100},
    parameter int              IALIGN        = 32,
    parameter int              FENCE_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_in,
    input  logic            stall,
    input  logic [2:0]      funct,
    input  logic            branch,
    input  logic            jump,
    input  logic            H_sel,
    input  logic            fence,
    input  logic            zero,
    input  logic            less_than,
    input  logic            less_than_u,
    input  logic [XLEN-1:0] Imm_H,
    input  logic [XLEN-1:0] alu_out_h,
    input  logic            drain_done,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] next_pc,
    output logic            flush,
    output logic            taken,
    output logic            misaligned,
    output logic [XLEN-1:0] bad_target,
    output logic            fence_busy,
    output logic            fence_err,
    output logic [XLEN-1:0] predecessor,
    output logic [XLEN-1:0] successor
);

    localparam int              CNT_W       = $clog2(FENCE_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(FENCE_TIMEOUT - 1);
    localparam logic [XLEN-1:0] PC_STEP     = {{(XLEN-3){1'b0}}, 3'd4};
    localparam logic [XLEN-1:0] LSB_CLEAR   = ~{{(XLEN-1){1'b0}}, 1'b1};
    localparam bit              CHECK_ALIGN = (IALIGN == 32);

    typedef enum logic [1:0] {
        ST_RUN          = 2'd0,
        ST_FENCE_WAIT   = 2'd1,
        ST_FENCE_RESUME = 2'd2
    } state_t;

    function automatic logic branch_cond(
        input logic [2:0] f3,
        input logic       eq,
        input logic       lt,
        input logic       ltu
    );
        logic c;
        case (f3)
            3'b000:  c = eq;
            3'b001:  c = ~eq;
            3'b100:  c = lt;
            3'b101:  c = ~lt;
            3'b110:  c = ltu;
            3'b111:  c = ~ltu;
            default: c = 1'b0;
        endcase
        return c;
    endfunction

    // JALR drops bit 0 of rs1+imm; everything else is PC-relative and wraps.
    function automatic logic [XLEN-1:0] redirect_target(
        input logic            is_jalr,
        input logic [XLEN-1:0] pc,
        input logic [XLEN-1:0] imm,
        input logic [XLEN-1:0] rs1_imm
    );
        logic [XLEN-1:0] t;
        if (is_jalr) t = rs1_imm & LSB_CLEAR;
        else         t = pc + imm;
        return t;
    endfunction

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pred;
    logic [XLEN-1:0] r_succ;
    logic [XLEN-1:0] r_bad;
    logic [CNT_W-1:0] r_cnt;
    logic            r_flush;
    logic            r_taken;
    logic            r_misal;
    logic            r_busy;
    logic            r_err;

    logic            w_accept;
    logic            w_cond;
    logic            w_redir;
    logic [XLEN-1:0] w_target;
    logic            w_misal;
    logic [XLEN-1:0] w_pc_plus4;

    assign w_accept   = valid_in & ~stall;
    assign w_cond     = branch_cond(funct, zero, less_than, less_than_u);
    assign w_redir    = jump | (branch & w_cond);
    assign w_target   = redirect_target(jump & ~H_sel, r_pc, Imm_H, alu_out_h);
    assign w_misal    = CHECK_ALIGN & w_target[1];
    assign w_pc_plus4 = r_pc + PC_STEP;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_VECTOR;
            r_pred  <= '0;
            r_succ  <= '0;
            r_bad   <= '0;
            r_cnt   <= '0;
            r_flush <= 1'b0;
            r_taken <= 1'b0;
            r_misal <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_flush <= 1'b0;
            r_taken <= 1'b0;
            r_misal <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (w_accept) begin
                        if (w_redir && w_misal) begin
                            r_pc    <= TRAP_VECTOR;
                            r_bad   <= w_target;
                            r_misal <= 1'b1;
                            r_flush <= 1'b1;
                        end else if (w_redir) begin
                            r_pc    <= w_target;
                            r_taken <= 1'b1;
                            r_flush <= 1'b1;
                        end else if (fence) begin
                            r_pred  <= r_pc;
                            r_succ  <= w_pc_plus4;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= ST_FENCE_WAIT;
                        end else begin
                            r_pc <= w_pc_plus4;
                        end
                    end
                end
                // Drain completion wins over a timeout landing in the same cycle.
                ST_FENCE_WAIT: begin
                    if (drain_done) begin
                        r_state <= ST_FENCE_RESUME;
                    end else if (r_cnt == CNT_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= ST_FENCE_RESUME;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_FENCE_RESUME: begin
                    r_pc    <= r_succ;
                    r_flush <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_RUN;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign pc_out      = r_pc;
    assign next_pc     = w_pc_plus4;
    assign flush       = r_flush;
    assign taken       = r_taken;
    assign misaligned  = r_misal;
    assign bad_target  = r_bad;
    assign fence_busy  = r_busy;
    assign fence_err   = r_err;
    assign predecessor = r_pred;
    assign successor   = r_succ;

endmodule
